// File: rtl/student_fir_sched_pkg.sv
// Shared types and constants for the FIR sample scheduler.
package student_fir_sched_pkg;

   // Scheduler states: wait for data, hand one sample to the chain, wait for completion.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_e;

   // Default bound on how long WAIT may last before giving up on the chain.
   localparam int TIMEOUT_CYCLES_DEF = 4096;

   // True whenever the scheduler owns a sample (anything but IDLE).
   function automatic logic state_is_busy(input sched_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/student_fir_sched_fifo.sv
// Sample queue: synchronous FIFO with one push and one pop per cycle.
// A push to a full queue is accepted only when a pop happens in the same cycle.
module student_fir_sched_fifo #(
   parameter int DATA_SIZE = 16,
   parameter int DEPTH     = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [DATA_SIZE-1:0]       push_data_i,
   input  logic                       pop_i,
   output logic [DATA_SIZE-1:0]       pop_data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_SIZE-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [LW-1:0]        r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == LW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = pop_i & ~w_empty;
   assign w_do_push = push_i & (~w_full | w_do_pop);

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + LW'(1);
            2'b01:   r_count <= r_count - LW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr] <= push_data_i;
   end

   assign pop_data_o = r_mem[r_rd_ptr];
   assign full_o     = w_full;
   assign empty_o    = w_empty;
   assign level_o    = r_count;

endmodule

// File: rtl/student_fir_sample_sched.sv
// Feeds audio and software samples, one at a time, into a parallel FIR chain.
// Strobe semantics: aud_valid_i is a level whose rising edge carries one sample;
// sw_valid_i and fir_done_i are single-cycle pulses; fir_valid_o is a single-cycle
// pulse with fir_sample_o valid in that cycle. There is no back-pressure: the
// chain must accept every fir_valid_o, and a sample that cannot be queued is
// dropped and reported through overflow_o.
module student_fir_sample_sched
   import student_fir_sched_pkg::*;
#(
   parameter int DATA_SIZE      = 16,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          aud_valid_i,
   input  logic [DATA_SIZE-1:0]          aud_sample_i,
   input  logic                          sw_valid_i,
   input  logic [DATA_SIZE-1:0]          sw_sample_i,
   output logic                          fir_valid_o,
   output logic [DATA_SIZE-1:0]          fir_sample_o,
   input  logic                          fir_done_i,
   input  logic                          clear_i,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
   output logic                          overflow_o,
   output logic                          timeout_o,
   output logic [1:0]                    dbg_state_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   sched_state_e         r_state;
   sched_state_e         w_state_nxt;

   logic                 r_aud_prev;
   logic                 r_aud_low_seen;
   logic                 w_aud_evt;

   logic                 r_skid_v;
   logic [DATA_SIZE-1:0] r_skid_data;
   logic                 w_skid_load;
   logic                 w_skid_drain;
   logic                 w_skid_ovf;

   logic                 w_push;
   logic [DATA_SIZE-1:0] w_push_data;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [LW-1:0]        w_level;
   logic [DATA_SIZE-1:0] w_head;
   logic                 w_fifo_ovf;

   logic [CW-1:0]        r_cnt;
   logic                 w_timeout_evt;

   logic [DATA_SIZE-1:0] r_fir_sample;
   logic                 r_overflow;
   logic                 r_timeout;

   // A rising edge only counts once the strobe has been seen low after reset, so a
   // level held high across reset release does not look like a fresh event.
   assign w_aud_evt = aud_valid_i & ~r_aud_prev & r_aud_low_seen;

   // Edge-detect history for the audio strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_aud_prev     <= 1'b0;
         r_aud_low_seen <= 1'b0;
      end else begin
         r_aud_prev <= aud_valid_i;
         if (!aud_valid_i) r_aud_low_seen <= 1'b1;
      end
   end

   // Write arbitration: audio has priority, a colliding sw sample parks in the skid
   // register and drains on the next cycle without an audio event. A sw pulse that
   // finds the skid occupied replaces the parked sample and flags the loss.
   always_comb begin
      w_push       = 1'b0;
      w_push_data  = aud_sample_i;
      w_skid_load  = 1'b0;
      w_skid_drain = 1'b0;
      w_skid_ovf   = 1'b0;
      if (w_aud_evt) begin
         w_push      = 1'b1;
         w_push_data = aud_sample_i;
         if (sw_valid_i) begin
            w_skid_load = 1'b1;
            w_skid_ovf  = r_skid_v;
         end
      end else if (r_skid_v) begin
         if (sw_valid_i) begin
            w_skid_load = 1'b1;
            w_skid_ovf  = 1'b1;
         end else begin
            w_push       = 1'b1;
            w_push_data  = r_skid_data;
            w_skid_drain = 1'b1;
         end
      end else if (sw_valid_i) begin
         w_push      = 1'b1;
         w_push_data = sw_sample_i;
      end
   end

   // One-entry skid register for sw samples that lost arbitration.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_skid_v    <= 1'b0;
         r_skid_data <= '0;
      end else if (w_skid_load) begin
         r_skid_v    <= 1'b1;
         r_skid_data <= sw_sample_i;
      end else if (w_skid_drain) begin
         r_skid_v    <= 1'b0;
      end
   end

   assign w_pop      = (r_state == ISSUE);
   assign w_fifo_ovf = w_push & w_full & ~w_pop;

   student_fir_sched_fifo #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (w_push),
      .push_data_i (w_push_data),
      .pop_i       (w_pop),
      .pop_data_o  (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .level_o     (w_level)
   );

   // Next-state logic; a done pulse in ISSUE or WAIT ends the transaction, in IDLE it is ignored.
   always_comb begin
      w_state_nxt   = r_state;
      w_timeout_evt = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            if (fir_done_i) w_state_nxt = IDLE;
            else            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (fir_done_i) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt   = IDLE;
               w_timeout_evt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register; the head sample is captured on entry to ISSUE and held afterwards.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_fir_sample <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_state_nxt == ISSUE) r_fir_sample <= w_head;
      end
   end

   // WAIT-duration counter: zeroed in ISSUE so the first WAIT cycle sees 0.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_cnt <= '0;
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Sticky error flags; a new event in the same cycle as clear_i keeps the flag set.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_skid_ovf || w_fifo_ovf) r_overflow <= 1'b1;
         else if (clear_i)             r_overflow <= 1'b0;
         if (w_timeout_evt)            r_timeout  <= 1'b1;
         else if (clear_i)             r_timeout  <= 1'b0;
      end
   end

   assign fir_valid_o  = (r_state == ISSUE);
   assign fir_sample_o = r_fir_sample;
   assign busy_o       = state_is_busy(r_state);
   assign fifo_level_o = w_level;
   assign overflow_o   = r_overflow;
   assign timeout_o    = r_timeout;
   assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_student_fir_sample_sched.sv
// Directed bench for the FIR sample scheduler (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_student_fir_sample_sched;

   logic        clk;
   logic        rst;
   logic        aud_valid;
   logic [15:0] aud_sample;
   logic        sw_valid;
   logic [15:0] sw_sample;
   logic        fir_valid;
   logic [15:0] fir_sample;
   logic        fir_done;
   logic        clear;
   logic        busy;
   logic [2:0]  level;
   logic        overflow;
   logic        timeout;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] issued_q[$];
   int          issued_cyc_q[$];
   logic [15:0] exp_q[$];

   student_fir_sample_sched #(
      .DATA_SIZE      (16),
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .aud_valid_i  (aud_valid),
      .aud_sample_i (aud_sample),
      .sw_valid_i   (sw_valid),
      .sw_sample_i  (sw_sample),
      .fir_valid_o  (fir_valid),
      .fir_sample_o (fir_sample),
      .fir_done_i   (fir_done),
      .clear_i      (clear),
      .busy_o       (busy),
      .fifo_level_o (level),
      .overflow_o   (overflow),
      .timeout_o    (timeout),
      .dbg_state_o  (dbg_state)
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // record every issued sample mid-cycle
   always @(negedge clk) begin
      if (fir_valid) begin
         issued_q.push_back(fir_sample);
         issued_cyc_q.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (fir_valid) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; aud_valid = 1'b1; aud_sample = 16'h0F0F;
      sw_valid = 1'b1; sw_sample = 16'hF0F0;
      repeat (3) step();
      checks++;
      if (busy !== 1'b0 || level !== 3'd0 || fir_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%0b level=%0d valid=%0b required 0/0/0", busy, level, fir_valid);
      end
      checks++;
      if (fir_sample !== 16'h0 || overflow !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: sample=%h ovf=%0b to=%0b required 0000/0/0", fir_sample, overflow, timeout);
      end
      // release with the audio strobe still high: no event expected
      rst = 1'b0; sw_valid = 1'b0;
      repeat (6) step();
      checks++;
      if (level !== 3'd0 || busy !== 1'b0 || issued_q.size() !== 0) begin
         errors++;
         $display("FAIL reset_held_aud: level=%0d busy=%0b issued=%0d required 0/0/0", level, busy, issued_q.size());
      end
      aud_valid = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_single();
      int t;
      issued_q.delete(); issued_cyc_q.delete();
      t = cyc;
      aud_sample = 16'h1234; aud_valid = 1'b1;
      step();
      aud_valid = 1'b0;
      checks++;
      if (fir_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_t1: valid=%0b required 0", fir_valid);
      end
      step();
      checks++;
      if (fir_valid !== 1'b1 || fir_sample !== 16'h1234 || cyc !== t + 2) begin
         errors++;
         $display("FAIL single_t2: valid=%0b sample=%h cyc=%0d required 1/1234/%0d", fir_valid, fir_sample, cyc, t + 2);
      end
      repeat (10) step();
      fir_done = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_wait: busy=%0b required 1", busy);
      end
      step();
      fir_done = 1'b0;
      checks++;
      if (busy !== 1'b0 || fir_sample !== 16'h1234 || fir_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_after_done: busy=%0b sample=%h valid=%0b required 0/1234/0", busy, fir_sample, fir_valid);
      end
      checks++;
      if (issued_q.size() !== 1) begin
         errors++;
         $display("FAIL single_count: issued=%0d required 1", issued_q.size());
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int s0;
      issued_q.delete(); issued_cyc_q.delete();
      aud_sample = 16'h00AA; aud_valid = 1'b1;
      sw_sample = 16'h0055; sw_valid = 1'b1;
      step();
      sw_valid = 1'b0; aud_valid = 1'b0;
      wait_valid(10, ok);
      checks++;
      if (!ok || fir_sample !== 16'h00AA) begin
         errors++;
         $display("FAIL simul_first: found=%0b sample=%h required 1/00aa", ok, fir_sample);
      end
      s0 = cyc;
      step();
      fir_done = 1'b1;
      step();
      fir_done = 1'b0;
      wait_valid(10, ok);
      checks++;
      if (!ok || fir_sample !== 16'h0055 || cyc !== s0 + 3) begin
         errors++;
         $display("FAIL simul_second: found=%0b sample=%h cyc=%0d required 1/0055/%0d", ok, fir_sample, cyc, s0 + 3);
      end
      fir_done = 1'b1;
      step();
      fir_done = 1'b0;
      checks++;
      if (overflow !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL simul_flags: ovf=%0b busy=%0b required 0/0", overflow, busy);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      issued_q.delete(); issued_cyc_q.delete();
      for (int i = 1; i <= 6; i++) begin
         sw_valid = 1'b1; sw_sample = 16'(i);
         step();
      end
      sw_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         errors++;
         $display("FAIL ovf_set: ovf=%0b level=%0d required 1/4", overflow, level);
      end
      // clear colliding with another dropped sample: set wins
      sw_valid = 1'b1; sw_sample = 16'h0007; clear = 1'b1;
      step();
      sw_valid = 1'b0;
      checks++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         errors++;
         $display("FAIL ovf_clear_collide: ovf=%0b level=%0d required 1/4", overflow, level);
      end
      step();
      clear = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%0b required 0", overflow);
      end
      fir_done = 1'b1;
      step();
      fir_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_valid(10, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL ovf_drain_%0d: no issue within 10 cycles, required issue", k);
         end
         fir_done = 1'b1;
         step();
         fir_done = 1'b0;
      end
      repeat (5) step();
      exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
      checks++;
      if (issued_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL ovf_count: issued=%0d required %0d", issued_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (issued_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL ovf_order_%0d: got %h required %h", i, issued_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_full_pop();
      bit ok;
      issued_q.delete(); issued_cyc_q.delete();
      for (int i = 0; i < 5; i++) begin
         sw_valid = 1'b1; sw_sample = 16'h0011 + 16'(i);
         step();
      end
      sw_valid = 1'b0;
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_fill: level=%0d ovf=%0b required 4/0", level, overflow);
      end
      fir_done = 1'b1;
      step();
      fir_done = 1'b0;
      step();
      checks++;
      if (fir_valid !== 1'b1 || level !== 3'd4) begin
         errors++;
         $display("FAIL full_issue: valid=%0b level=%0d required 1/4", fir_valid, level);
      end
      sw_valid = 1'b1; sw_sample = 16'h0016;
      step();
      sw_valid = 1'b0;
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop: level=%0d ovf=%0b required 4/0", level, overflow);
      end
      fir_done = 1'b1;
      step();
      fir_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_valid(10, ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL full_drain_%0d: no issue within 10 cycles, required issue", k);
         end
         fir_done = 1'b1;
         step();
         fir_done = 1'b0;
      end
      repeat (4) step();
      exp_q = '{16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0016};
      checks++;
      if (issued_q.size() !== exp_q.size() || level !== 3'd0) begin
         errors++;
         $display("FAIL full_count: issued=%0d level=%0d required %0d/0", issued_q.size(), level, exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (issued_q[i] !== exp_q[i]) begin
               errors++;
               $display("FAIL full_order_%0d: got %h required %h", i, issued_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      sw_valid = 1'b1; sw_sample = 16'h0777;
      step();
      sw_valid = 1'b0;
      wait_valid(10, ok);
      checks++;
      if (!ok || timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_issue: found=%0b to=%0b required 1/0", ok, timeout);
      end
      // WAIT lasts TIMEOUT_CYCLES cycles (counter 0..15), so IDLE is reached one cycle later
      repeat (16) step();
      checks++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_last_wait: busy=%0b to=%0b required 1/0", busy, timeout);
      end
      step();
      checks++;
      if (busy !== 1'b0 || timeout !== 1'b1) begin
         errors++;
         $display("FAIL to_expired: busy=%0b to=%0b required 0/1", busy, timeout);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: to=%0b required 0", timeout);
      end
   endtask

   task automatic test_reset_mid_wait();
      bit ok;
      int n0;
      for (int i = 0; i < 3; i++) begin
         sw_valid = 1'b1; sw_sample = 16'h0100 + 16'(i);
         step();
      end
      sw_valid = 1'b0;
      checks++;
      if (level !== 3'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: level=%0d busy=%0b required 2/1", level, busy);
      end
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      n0 = issued_q.size();
      repeat (10) step();
      checks++;
      if (level !== 3'd0 || busy !== 1'b0 || issued_q.size() !== n0) begin
         errors++;
         $display("FAIL rst_post: level=%0d busy=%0b new_issues=%0d required 0/0/0", level, busy, issued_q.size() - n0);
      end
      aud_sample = 16'h0BEE; aud_valid = 1'b1;
      step();
      aud_valid = 1'b0;
      wait_valid(10, ok);
      checks++;
      if (!ok || fir_sample !== 16'h0BEE) begin
         errors++;
         $display("FAIL rst_resume: found=%0b sample=%h required 1/0bee", ok, fir_sample);
      end
      // done during ISSUE completes immediately
      fir_done = 1'b1;
      step();
      fir_done = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL done_in_issue: busy=%0b required 0", busy);
      end
   endtask

   task automatic test_level_strobe();
      int n0;
      n0 = issued_q.size();
      aud_sample = 16'h0A5A; aud_valid = 1'b1;
      step();
      aud_sample = 16'hFFFF;
      repeat (49) step();
      aud_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (issued_q.size() !== n0 + 1 || level !== 3'd0) begin
         errors++;
         $display("FAIL strobe_count: issues=%0d level=%0d required 1/0", issued_q.size() - n0, level);
      end else begin
         checks++;
         if (issued_q[n0] !== 16'h0A5A) begin
            errors++;
            $display("FAIL strobe_value: got %h required 0a5a", issued_q[n0]);
         end
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      rst = 1'b1; aud_valid = 1'b0; aud_sample = '0;
      sw_valid = 1'b0; sw_sample = '0; fir_done = 1'b0; clear = 1'b0;
      test_reset();
      test_single();
      test_simultaneous();
      test_overflow();
      test_full_pop();
      test_timeout();
      test_reset_mid_wait();
      test_level_strobe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
